// File: rtl/bht_lite_pkg.sv
// bht_lite_pkg: shared frontend branch-prediction types and sizing helpers
package bht_lite_pkg;
  localparam int VLEN = 32;
  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
  } bht_update_t;
  typedef struct packed {
    logic valid;
    logic taken;
  } bht_prediction_t;
  function automatic int row_size(input int rvc);
    return (rvc != 0) ? 2 : 1;
  endfunction
  function automatic int row_bits(input int nr_entries, input int rvc);
    return $clog2(nr_entries / row_size(rvc));
  endfunction
endpackage

// File: rtl/bht_lite_if.sv
// bht_lite_if: predict/update bundle between fetch, branch resolve and the BHT
interface bht_lite_if
  import bht_lite_pkg::*;
#(
  parameter int ROW_SIZE = 2
);
  logic [VLEN-1:0]                  vpc_i;
  bht_update_t                      bht_update_i;
  bht_prediction_t [ROW_SIZE-1:0]   bht_prediction_o;
  modport master(output vpc_i, bht_update_i, input bht_prediction_o);
  modport slave(input vpc_i, bht_update_i, output bht_prediction_o);
endinterface

// File: rtl/bht_lite_sat_counter2.sv
// bht_lite_sat_counter2: 2-bit saturating up/down counter with weakly-biased initial load
module bht_lite_sat_counter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       load_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);
  logic [1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = !en_i   ? cnt_q :
            load_i  ? (taken_i ? 2'b10 : 2'b01) :
            taken_i ? ((cnt_q == 2'b11) ? cnt_q : cnt_q + 2'b01) :
                      ((cnt_q == 2'b00) ? cnt_q : cnt_q - 2'b01);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= 2'b00;
    else       cnt_q <= cnt_d;
  end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/bht_lite.sv
// bht_lite: PC-indexed 2-bit counter branch history table, untagged, one row per fetch block
module bht_lite
  import bht_lite_pkg::*;
#(
  parameter int NR_ENTRIES = 32,
  parameter int RVC        = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_bp_i,
  input  logic        debug_mode_i,
  bht_lite_if.slave   bht
);
  localparam int ROW_SIZE = row_size(RVC);
  localparam int NR_ROWS  = NR_ENTRIES / ROW_SIZE;
  localparam int ROW_BITS = row_bits(NR_ENTRIES, RVC);
  logic [NR_ROWS-1:0][ROW_SIZE-1:0]       valid_q, valid_d;
  logic [NR_ROWS-1:0][ROW_SIZE-1:0][1:0]  cnt;
  logic [ROW_BITS-1:0]                    upd_row, pred_row;
  logic                                   upd_slot, upd_en, unused_pc;
  assign upd_row   = bht.bht_update_i.pc[ROW_BITS+1:2];
  assign upd_slot  = (RVC != 0) ? bht.bht_update_i.pc[1] : 1'b0;
  assign pred_row  = bht.vpc_i[ROW_BITS+1:2];
  // flush wins over a same-cycle update, so the update is simply dropped
  assign upd_en    = bht.bht_update_i.valid && !debug_mode_i && !flush_bp_i;
  assign unused_pc = ^{bht.vpc_i[VLEN-1:ROW_BITS+2], bht.vpc_i[1:0],
                       bht.bht_update_i.pc[VLEN-1:ROW_BITS+2], bht.bht_update_i.pc[1:0]};
  always_comb begin
    valid_d = flush_bp_i ? '0 : valid_q;
    if (upd_en) valid_d[upd_row][upd_slot] = 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) valid_q <= '0;
    else       valid_q <= valid_d;
  end
  for (genvar r = 0; r < NR_ROWS; r++) begin : g_row
    for (genvar s = 0; s < ROW_SIZE; s++) begin : g_slot
      bht_lite_sat_counter2 u_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (upd_en && (upd_row == ROW_BITS'(r)) && (upd_slot == 1'(s))),
        .load_i  (!valid_q[r][s]),
        .taken_i (bht.bht_update_i.taken),
        .cnt_o   (cnt[r][s])
      );
    end
  end
  for (genvar s = 0; s < ROW_SIZE; s++) begin : g_pred
    assign bht.bht_prediction_o[s].valid = valid_q[pred_row][s];
    assign bht.bht_prediction_o[s].taken = cnt[pred_row][s][1];
  end
endmodule

// File: tb/tb_bht_lite.sv
// tb_bht_lite: directed vectors with queued expectations checked by an independent monitor
module tb_bht_lite;
  import bht_lite_pkg::*;
  typedef struct {
    string      name;
    logic [3:0] exp;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1, flush = 1'b0, dbg = 1'b0, chk_v = 1'b0;
  exp_t sb[$];
  int   vectors = 0, miscompares = 0;
  bht_lite_if #(.ROW_SIZE(2)) bif ();
  bht_lite #(.NR_ENTRIES(32), .RVC(1)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_bp_i   (flush),
    .debug_mode_i (dbg),
    .bht          (bif.slave)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (chk_v) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty: got %b, required an expected entry", bif.bht_prediction_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bif.bht_prediction_o !== e.exp) begin
          miscompares++;
          $display("FAIL %s: got {v1,t1,v0,t0}=%b, required %b", e.name, bif.bht_prediction_o, e.exp);
        end
      end
    end
  end
  task automatic step(input string nm, input logic [31:0] vpc, input logic uv, input logic [31:0] upc,
                      input logic ut, input logic fl, input logic dm, input logic r,
                      input logic chk, input logic [3:0] exp);
    @(posedge clk);
    #1;
    bif.vpc_i              = vpc;
    bif.bht_update_i.valid = uv;
    bif.bht_update_i.pc    = upc;
    bif.bht_update_i.taken = ut;
    flush = fl;
    dbg   = dm;
    rst   = r;
    chk_v = chk;
    if (chk) sb.push_back('{nm, exp});
  endtask
  localparam logic [31:0] B = 32'h8000_0000;
  initial begin
    bif.vpc_i        = '0;
    bif.bht_update_i = '0;
    step("rst0", B, 0, 0, 0, 0, 0, 1, 0, 4'b0000);
    step("rst1", B, 0, 0, 0, 0, 0, 1, 0, 4'b0000);
    for (int r = 0; r < 16; r++) step($sformatf("sweep_row%0d", r), B + 32'(r * 4), 0, 0, 0, 0, 0, 0, 1, 4'b0000);
    step("train_a",   B+4, 1, B+4, 1, 0, 0, 0, 1, 4'b0000);
    step("train_b",   B+4, 1, B+4, 1, 0, 0, 0, 1, 4'b0011);
    step("train_c",   B+4, 1, B+4, 1, 0, 0, 0, 1, 4'b0011);
    step("train_d",   B+4, 1, B+4, 0, 0, 0, 0, 1, 4'b0011);
    step("train_e",   B+4, 1, B+4, 0, 0, 0, 0, 1, 4'b0011);
    step("train_f",   B+4, 1, B+4, 0, 0, 0, 0, 1, 4'b0010);
    step("train_g",   B+4, 1, B+4, 0, 0, 0, 0, 1, 4'b0010);
    step("sat_low",   B+4, 1, B+4, 1, 0, 0, 0, 1, 4'b0010);
    step("sat_low_1", B+4, 0, 0,   0, 0, 0, 0, 1, 4'b0010);
    step("same_j",    B+8, 1, B+8, 0, 0, 0, 0, 1, 4'b0000);
    step("same_k",    B+8, 1, B+8, 1, 0, 0, 0, 1, 4'b0010);
    step("same_l",    B+8, 0, 0,   0, 0, 0, 0, 1, 4'b0011);
    step("rvc_upd",   B+4, 1, B+6, 1, 0, 0, 0, 1, 4'b0010);
    step("rvc_slot1", B+4, 0, 0,   0, 0, 0, 0, 1, 4'b1110);
    step("alias_upd", B+32'h10, 1, B+32'h10, 1, 0, 0, 0, 1, 4'b0000);
    step("alias_hit", B+32'h50, 0, 0, 0, 0, 0, 0, 1, 4'b0011);
    step("alias_mis", B+32'h20, 0, 0, 0, 0, 0, 0, 1, 4'b0000);
    step("dbg_upd",   B+32'h20, 1, B+32'h20, 1, 0, 1, 0, 1, 4'b0000);
    step("dbg_after", B+32'h20, 0, 0, 0, 0, 0, 0, 1, 4'b0000);
    step("flush_cyc", B+4, 1, B+32'h28, 1, 1, 0, 0, 1, 4'b1110);
    step("flush_r1",  B+4, 0, 0, 0, 0, 0, 0, 1, 4'b0100);
    step("flush_upd", B+32'h28, 0, 0, 0, 0, 0, 0, 1, 4'b0000);
    step("flush_r4",  B+32'h10, 0, 0, 0, 0, 0, 0, 1, 4'b0001);
    step("post_fl_t", B+32'h10, 1, B+32'h10, 1, 0, 0, 0, 1, 4'b0001);
    step("post_fl_n", B+32'h10, 1, B+32'h10, 0, 0, 0, 0, 1, 4'b0011);
    step("post_fl_c", B+32'h10, 0, 0, 0, 0, 0, 0, 1, 4'b0010);
    step("mid_rst",   B+4, 1, B+4, 1, 0, 0, 1, 0, 4'b0000);
    step("rst_r1",    B+4, 0, 0, 0, 0, 0, 0, 1, 4'b0000);
    step("rst_r2",    B+8, 0, 0, 0, 0, 0, 0, 1, 4'b0000);
    step("rst_r4",    B+32'h10, 0, 0, 0, 0, 0, 0, 1, 4'b0000);
    step("retrain",   B+32'h10, 1, B+32'h10, 1, 0, 0, 0, 1, 4'b0000);
    step("retrain_c", B+32'h10, 0, 0, 0, 0, 0, 0, 1, 4'b0011);
    step("idle",      B, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bht_lite.md
# bht_lite

Branch history table for the CVA6 embedded frontend, sized by the configuration's `BHTEntries`, `RVC` and `XLEN` fields. It keeps 2-bit saturating counters indexed by fetch PC and gives a per-slot taken/not-taken prediction for the current fetch block. The frontend's branch-resolve path trains it. It sits between the fetch address generator (predict side) and the controller/branch unit (update side), next to the RAS.

## Interface
- `NR_ENTRIES`, 32: total counters; power of two, at least `ROW_SIZE`.
- `VLEN`, 32: virtual PC width.
- `RVC`, 1: compressed support; `ROW_SIZE` = 2 if 1, else 1.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; one clock; reset is synchronous and active-high.
- `flush_bp_i`  in  1  invalidate all entries (fence.i / debug entry).
- `debug_mode_i`  in  1  when high, updates are dropped.
- `vpc_i`  in  VLEN  fetch PC to predict.
- `bht_update_i`  in  bht_update_t  {valid, pc[VLEN], taken}, from branch resolve.
- `bht_prediction_o`  out  ROW_SIZE x bht_prediction_t  {valid, taken} per slot.

## Operation
- Storage: `NR_ROWS` = `NR_ENTRIES`/`ROW_SIZE` rows. Each entry has a valid bit and a 2-bit counter, held in flops.
- Index: `ROW_BITS` = log2(`NR_ROWS`). Row = `pc[ROW_BITS+1:2]`. Slot = `pc[1]` when `RVC`=1, otherwise 0.
- Predict (combinational): the output for slot s comes from row(`vpc_i`). `valid` = entry valid, `taken` = counter[1].
- Update takes effect on the next rising edge when `bht_update_i.valid` is high and `debug_mode_i` is low. The target is row(pc) at slot(pc).
  - Entry invalid: set valid. Counter = 2'b10 if taken, else 2'b01 (weakly biased).
  - Entry valid: counter +1 if taken, saturating at 2'b11. Counter −1 if not taken, saturating at 2'b00.
- Priority: `rst_i` > `flush_bp_i` > update.
  - A flush clears every valid bit on that edge, and any same-cycle update is discarded.
  - Counters are not required to clear on flush.
- Aliasing is accepted. PCs differing only above bit `ROW_BITS+1` share an entry, with no tag.

## Timing
- Reset: all valid bits 0 and all counters 2'b00. Every `bht_prediction_o` slot reads {0,0} from the first cycle after reset.
- Predict latency 0: the output follows `vpc_i` within the same cycle.
- Update latency 1: an update applied at edge N is visible to predictions from cycle N+1.
- Same cycle update and predict to the same entry: the prediction shows the pre-update value, with no bypass.
- Flush at edge N: all predictions are invalid from cycle N+1. An update in cycle N+1 trains normally and starts from the invalid-entry rule.
- Reset asserted mid-training: entries return to the reset state on that edge. There is no partial-state carry-over.
- Counter arithmetic is 2-bit unsigned with explicit saturation, and never wraps (11+1 stays 11, 00−1 stays 00).

## Structure
- Shared frontend types package holds `bht_update_t`, `bht_prediction_t` and a function computing `ROW_BITS`/`ROW_SIZE` from the config fields. The fetch stage and the branch unit import these.
- One sub-module is natural: `sat_counter2`, a 2-bit saturating up/down counter with a load-initial input, instantiated once per entry.
- The top module holds the valid array, index/slot decode and the priority logic. Expected size is 150–250 lines.

## Test plan
- Reset, then sweep `vpc_i` across all rows → every slot reads {valid=0, taken=0}.
- Update pc=0x8000_0004 taken, once → the next cycle, predict 0x8000_0004 reads slot 0 {1,1} with counter 10. After two more taken updates the counter is 11. After one not-taken it reads taken=1 (counter 10). After two more not-taken it reads taken=0 (counter 01 then 00). Further not-taken updates stay at 00.
- RVC slot test: update pc=0x8000_0006 taken → predict 0x8000_0004 gives slot 1 {1,1} and slot 0 {0,0}.
- Aliasing (`NR_ENTRIES`=32, `RVC`=1): train 0x8000_0010 taken → predict 0x8000_0050 (+64) reads {1,1}. 0x8000_0020 stays invalid.
- Same-cycle update and predict on 0x8000_0008, entry at 01 with a taken update → the output that cycle is taken=0 and the next cycle is taken=1.
- Flush together with an update → all slots are invalid the next cycle and the update is lost. With `debug_mode_i`=1, an update leaves the entry unchanged. A mid-training `rst_i` returns all entries to {0,0}.
